// File: rtl/uart_width_down.sv
// Word-to-chunk serialiser: a small FIFO of {word, len} whose head word
// is emitted OUT_W bits at a time, LSB- or MSB-chunk first.
module uart_width_down #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wren,
    input  logic [IN_W-1:0]                   din,
    input  logic [$clog2(IN_W/OUT_W):0]       len,
    output logic                              full,
    input  logic                              rden,
    output logic [OUT_W-1:0]                  dout,
    output logic                              valid,
    output logic                              last,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              ovf
);

    localparam int R  = IN_W / OUT_W;
    localparam int KW = $clog2(R);
    localparam int LW = KW + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IN_W-1:0] word_mem_q [DEPTH];
    logic [LW-1:0]   len_mem_q  [DEPTH];

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [KW-1:0] k_q, k_d;
    logic          ovf_q, ovf_d;

    logic [LW-1:0] len_eff;
    logic [LW-1:0] hlen;
    logic [KW-1:0] idx;
    logic          wr_ok;
    logic          pop;
    logic          adv;

    // Stored length is normalised so the head compare never sees 0 or >R.
    assign len_eff = (len == '0 || len > LW'(R)) ? LW'(R) : len;

    assign full  = (count_q == CW'(DEPTH));
    assign valid = (count_q != '0);
    assign count = count_q;
    assign ovf   = ovf_q;

    assign hlen = len_mem_q[rd_q];
    assign last = valid && ({1'b0, k_q} == hlen - LW'(1));
    assign idx  = (MSB_FIRST != 0) ? KW'(R - 1) - k_q : k_q;

    assign wr_ok = wren && !full;
    assign pop   = rden && last;
    assign adv   = rden && valid && !last;

    always_comb begin
        dout = '0;
        for (int i = 0; i < R; i++) begin
            if (valid && idx == KW'(i)) begin
                dout = word_mem_q[rd_q][i*OUT_W +: OUT_W];
            end
        end
    end

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        k_d     = k_q;
        count_d = count_q;
        ovf_d   = ovf_q | (wren & full);
        if (wr_ok) begin
            wr_d = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
            k_d  = '0;
        end else if (adv) begin
            k_d = k_q + KW'(1);
        end
        unique case ({wr_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            k_q     <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            k_q     <= k_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Contents are qualified by count, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            word_mem_q[wr_q] <= din;
            len_mem_q[wr_q]  <= len_eff;
        end
    end

endmodule

// File: tb/tb_uart_width_down.sv
// Bench for uart_width_down: LSB-first and MSB-first instances share stimulus
// and are checked against per-instance queues of expected chunks.
module tb_uart_width_down;

    logic        clk;
    logic        rst_n;
    logic        wren;
    logic [31:0] din;
    logic [2:0]  len;
    logic        rden;

    logic       full0, valid0, last0, ovf0;
    logic [7:0] dout0;
    logic [1:0] count0;
    logic       full1, valid1, last1, ovf1;
    logic [7:0] dout1;
    logic [1:0] count1;

    logic [8:0] q0[$];
    logic [8:0] q1[$];

    int total = 0;
    int bad   = 0;

    uart_width_down u0 (
        .clk(clk), .rst_n(rst_n), .wren(wren), .din(din), .len(len),
        .full(full0), .rden(rden), .dout(dout0), .valid(valid0),
        .last(last0), .count(count0), .ovf(ovf0)
    );

    uart_width_down #(.MSB_FIRST(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wren(wren), .din(din), .len(len),
        .full(full1), .rden(rden), .dout(dout1), .valid(valid1),
        .last(last1), .count(count1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] w, input logic [2:0] l);
        int n;
        n = (l == 0 || l > 4) ? 4 : int'(l);
        for (int k = 0; k < n; k++) begin
            q0.push_back({k == n - 1, w[k*8 +: 8]});
            q1.push_back({k == n - 1, w[(3-k)*8 +: 8]});
        end
    endtask

    task automatic put_word(input logic [31:0] w, input logic [2:0] l);
        wren = 1'b1;
        din  = w;
        len  = l;
        push_exp(w, l);
        tick();
        wren = 1'b0;
    endtask

    task automatic step();
        logic [8:0] e0, e1;
        rden = 1'b1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        chk("valid0", valid0, 1);
        chk("dout0", dout0, e0[7:0]);
        chk("last0", last0, e0[8]);
        chk("valid1", valid1, 1);
        chk("dout1", dout1, e1[7:0]);
        chk("last1", last1, e1[8]);
        tick();
    endtask

    task automatic hold();
        rden = 1'b0;
        chk("hold_dout0", dout0, q0[0][7:0]);
        chk("hold_last0", last0, q0[0][8]);
        chk("hold_dout1", dout1, q1[0][7:0]);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && q0.size() > 0; i++) step();
        rden = 1'b0;
        chk("drain_left", q0.size(), 0);
        chk("empty_valid0", valid0, 0);
        chk("empty_count0", count0, 0);
        chk("empty_dout0", dout0, 0);
        chk("empty_valid1", valid1, 0);
    endtask

    task automatic chk_rst();
        chk("rst_count0", count0, 0);
        chk("rst_valid0", valid0, 0);
        chk("rst_dout0", dout0, 0);
        chk("rst_last0", last0, 0);
        chk("rst_full0", full0, 0);
        chk("rst_ovf0", ovf0, 0);
        chk("rst_count1", count1, 0);
        chk("rst_dout1", dout1, 0);
        chk("rst_ovf1", ovf1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        wren  = 1'b0;
        rden  = 1'b0;
        din   = '0;
        len   = '0;
        @(negedge clk);
        chk_rst();
        rst_n = 1'b1;
        tick();

        // full word, rden already high at the write edge
        rden = 1'b1;
        put_word(32'h0cabcdef, 3'd4);
        chk("lat_count0", count0, 1);
        drain();

        // short length then zero length, back to back
        put_word(32'h0cabcdef, 3'd3);
        put_word(32'h0cabcdef, 3'd0);
        chk("two_full0", full0, 1);
        drain();

        // fill, overflow, drain without gaps
        put_word(32'h11223344, 3'd4);
        put_word(32'h55667788, 3'd4);
        chk("fill_count0", count0, 2);
        chk("fill_full0", full0, 1);
        chk("fill_ovf0", ovf0, 0);
        wren = 1'b1;
        din  = 32'haabbccdd;
        len  = 3'd0;
        tick();
        wren = 1'b0;
        chk("drop_ovf0", ovf0, 1);
        chk("drop_ovf1", ovf1, 1);
        chk("drop_count0", count0, 2);
        drain();

        // stalls mid-word
        put_word(32'h0cabcdef, 3'd4);
        hold();
        hold();
        step();
        hold();
        hold();
        drain();

        // read strobe while empty
        rden = 1'b1;
        tick();
        rden = 1'b0;
        chk("idle_count0", count0, 0);
        chk("idle_valid0", valid0, 0);
        chk("idle_dout0", dout0, 0);

        // asynchronous reset after two chunks
        put_word(32'h0cabcdef, 3'd4);
        step();
        step();
        #2 rst_n = 1'b0;
        #1 chk_rst();
        q0.delete();
        q1.delete();
        rden = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        put_word(32'h01020304, 3'd4);
        drain();

        // write while full and popping is still dropped
        put_word(32'hdeadbeef, 3'd2);
        put_word(32'h00c0ffee, 3'd1);
        chk("pf_full0", full0, 1);
        step();
        wren = 1'b1;
        din  = 32'h12345678;
        len  = 3'd0;
        step();
        wren = 1'b0;
        chk("pf_count0", count0, 1);
        chk("pf_ovf0", ovf0, 1);

        // write and pop at the same edge keep count
        wren = 1'b1;
        din  = 32'h87654321;
        len  = 3'd4;
        push_exp(32'h87654321, 3'd4);
        step();
        wren = 1'b0;
        chk("wp_count0", count0, 1);
        chk("wp_count1", count1, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_width_down.md
UART_WIDTH_DOWN -- requirements
Module: uart_width_down

Interface
- REQ-001 SHALL have parameter IN_W, default 32: input word width in bits.
- REQ-002 SHALL have parameter OUT_W, default 8: output chunk width; IN_W SHALL be an integer multiple of OUT_W with R = IN_W/OUT_W >= 2.
- REQ-003 SHALL have parameter DEPTH, default 2: word storage capacity (power of 2, >= 2), including the word being serialised.
- REQ-004 SHALL have parameter MSB_FIRST, default 0: 0 = least-significant chunk first, 1 = most-significant chunk first.
- REQ-005 clk  input  1  sole clock; all state changes on rising edge.
- REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-007 wren  input  1  write strobe for din/len.
- REQ-008 din  input  IN_W  word to serialise.
- REQ-009 len  input  $clog2(R)+1  number of chunks to emit from din; 0 or >R means R.
- REQ-010 full  output  1  count == DEPTH; writes ignored.
- REQ-011 rden  input  1  consume current chunk.
- REQ-012 dout  output  OUT_W  current chunk, 0 when valid=0.
- REQ-013 valid  output  1  dout holds a chunk (count != 0).
- REQ-014 last  output  1  dout is the final chunk of its word (qualified by valid).
- REQ-015 count  output  $clog2(DEPTH+1)  words stored, including the active word.
- REQ-016 ovf  output  1  sticky: a write was dropped.

Function
- REQ-017 Storage SHALL be a DEPTH-entry FIFO of {din, effective len}; the head entry is the active word; write and read pointers wrap modulo DEPTH.
- REQ-018 wren=1 with full=0 SHALL store the word at the rising edge; valid SHALL be 1 in the following cycle when count was 0 (one-cycle latency).
- REQ-019 wren=1 with full=1 SHALL drop the word and set ovf, even if a pop frees an entry at the same edge.
- REQ-020 A chunk index k (0..len-1) SHALL select dout = word[k*OUT_W +: OUT_W] when MSB_FIRST=0, and word[(R-1-k)*OUT_W +: OUT_W] when MSB_FIRST=1.
- REQ-021 last SHALL be 1 when valid=1 and k == len-1.
- REQ-022 rden=1 with valid=1 SHALL advance k by 1; with last=1 it SHALL instead pop the head, reset k to 0, and present the next word's chunk 0 in the next cycle with no bubble.
- REQ-023 rden=1 with valid=0 SHALL have no effect.
- REQ-024 rden=0 SHALL hold dout, k, last and count unchanged (stall).
- REQ-025 A write and a pop at the same edge with full=0 SHALL leave count unchanged, and both SHALL take effect.
- REQ-026 count SHALL increment on an accepted write only, decrement on a pop only, and never exceed DEPTH or underflow.
- REQ-027 A write into an empty block while rden=1 SHALL NOT be consumed at the write edge; chunk 0 is first visible the next cycle.

Reset
- REQ-028 rst_n=0 SHALL immediately force count=0, full=0, valid=0, last=0, dout=0, ovf=0, k=0, and pointers=0, independent of clk.
- REQ-029 Reset mid-word SHALL discard all stored words and any partially emitted word; FIFO contents need not be cleared.
- REQ-030 The first accepted write after rst_n deasserts SHALL be serialised from chunk 0.
- REQ-031 ovf SHALL clear only on reset.

Verification
- REQ-032 Defaults; write 32'h0cabcdef, len=4; rden=1 held -> dout ef, cd, ab, 0c on 4 consecutive cycles; last on 0c; then valid=0, count=0.
- REQ-033 Write 32'h0cabcdef, len=3 -> ef, cd, ab with last on ab. Repeat with len=0 -> 4 chunks, ending with 0c.
- REQ-034 MSB_FIRST=1; write 32'h0cabcdef, len=4 -> 0c, ab, cd, ef. Write with len=2 -> 0c, ab.
- REQ-035 Write 32'h11223344 then 32'h55667788 on consecutive cycles with rden=0 -> count=2, full=1. Third write 32'haabbccdd -> dropped, ovf=1. Then rden=1 -> 44 33 22 11 88 77 66 55 with no gap.
- REQ-036 Interleave rden=0 cycles mid-word -> dout and last held. Pulse rden with valid=0 -> count stays 0, no output.
- REQ-037 Assert rst_n=0 mid-cycle after 2 of 4 chunks -> all outputs 0 before the next clk edge. After release, write 32'h01020304 -> 04 first.
